split_radio_array: RTL and testbench

//  Parametrised successor to the two-way radio/wired splitter. Accepts one receive word

---
 rtl/split_radio_array.sv | 125 ++++++++++++
 tb/tb_split_radio_array.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/split_radio_array.sv
// split_radio_array
//   Steers one receive word stream to one of CHANNELS outputs, to every output
//   (broadcast), or to trash. Each channel owns an elastic DEPTH-stage delay
//   line with valid/ready handshaking, so a stalled consumer only blocks words
//   aimed at its own channel.
//
// Ports
//   Clock          in   rising-edge clock
//   Reset_n        in   asynchronous reset, active low
//   Receive        in   [WIDTH]            input word
//   Receive_Valid  in                      input word valid
//   Receive_Ready  out                     input word can be accepted this cycle
//   Route          in   [ROUTE_W]          target channel, >= CHANNELS means trash
//   Broadcast      in                      copy the word to every channel
//   Out_Data       out  [CHANNELS*WIDTH]   channel c on bits [c*WIDTH +: WIDTH]
//   Out_Valid      out  [CHANNELS]         per-channel output valid
//   Out_Ready      in   [CHANNELS]         per-channel consumer ready
//   Trash_Count    out  [16]               saturating dropped-word count
//
// Build option
//   SPLIT_RADIO_TRASH_COUNT_EN : adds the Trash_Count port and its counter.
//   Without it, trashed words are dropped silently.

module split_radio_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  localparam int ROUTE_W = $clog2(CHANNELS) + 1
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [WIDTH-1:0]          Receive,
  input  logic                      Receive_Valid,
  output logic                      Receive_Ready,
  input  logic [ROUTE_W-1:0]        Route,
  input  logic                      Broadcast,
`ifdef SPLIT_RADIO_TRASH_COUNT_EN
  output logic [15:0]               Trash_Count,
`endif
  output logic [CHANNELS*WIDTH-1:0] Out_Data,
  output logic [CHANNELS-1:0]       Out_Valid,
  input  logic [CHANNELS-1:0]       Out_Ready
);

  logic [CHANNELS-1:0] stage0_free;
  logic [CHANNELS-1:0] load;
  logic                route_trash;
  logic                route_free;
  logic                accept;

  // Ready is built only from stage state, Route, Broadcast and Out_Ready so it
  // never loops back through Receive_Valid.
  always_comb begin
    route_trash = (int'(Route) >= CHANNELS);
    route_free  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(Route) == c) route_free = stage0_free[c];
    end
    if (Broadcast)        Receive_Ready = &stage0_free;
    else if (route_trash) Receive_Ready = 1'b1;
    else                  Receive_Ready = route_free;
    accept = Receive_Valid & Receive_Ready;
    for (int c = 0; c < CHANNELS; c++) begin
      load[c] = accept & (Broadcast | (int'(Route) == c));
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] adv;

    // Advance is resolved from the output end backwards so a full line moves
    // as a whole when the consumer takes a word, which keeps it bubble-free.
    always_comb begin
      adv = '0;
      adv[DEPTH-1] = valid_q[DEPTH-1] & Out_Ready[c];
      for (int s = DEPTH - 2; s >= 0; s--) begin
        adv[s] = valid_q[s] & (~valid_q[s+1] | adv[s+1]);
      end
    end

    assign stage0_free[c] = ~valid_q[0] | adv[0];

    // A stage is refilled from its predecessor when that one advances,
    // otherwise it empties if its own word moved on. Stage 0 is refilled
    // from the input on a load.
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        valid_q <= '0;
        for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      end else begin
        if (load[c]) begin
          data_q[0]  <= Receive;
          valid_q[0] <= 1'b1;
        end else if (adv[0]) begin
          valid_q[0] <= 1'b0;
        end
        for (int s = 1; s < DEPTH; s++) begin
          if (adv[s-1]) begin
            data_q[s]  <= data_q[s-1];
            valid_q[s] <= 1'b1;
          end else if (adv[s]) begin
            valid_q[s] <= 1'b0;
          end
        end
      end
    end

    assign Out_Data[c*WIDTH +: WIDTH] = data_q[DEPTH-1];
    assign Out_Valid[c]               = valid_q[DEPTH-1];
  end

`ifdef SPLIT_RADIO_TRASH_COUNT_EN
  logic trash_accept;
  assign trash_accept = accept & ~Broadcast & route_trash;

  // Counter holds at all-ones rather than wrapping.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                                   Trash_Count <= '0;
    else if (trash_accept && Trash_Count != 16'hFFFF) Trash_Count <= Trash_Count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_split_radio_array.sv
// tb_split_radio_array
//   Directed bench for split_radio_array (WIDTH=8, CHANNELS=2, DEPTH=4).
//   Accepted words are pushed into per-channel expectation queues and popped
//   when the channel hands a word to its consumer.

module tb_split_radio_array;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 4;
  localparam int ROUTE_W  = $clog2(CHANNELS) + 1;

  logic                      Clock;
  logic                      Reset_n;
  logic [WIDTH-1:0]          Receive;
  logic                      Receive_Valid;
  logic                      Receive_Ready;
  logic [ROUTE_W-1:0]        Route;
  logic                      Broadcast;
  logic [CHANNELS*WIDTH-1:0] Out_Data;
  logic [CHANNELS-1:0]       Out_Valid;
  logic [CHANNELS-1:0]       Out_Ready;
`ifdef SPLIT_RADIO_TRASH_COUNT_EN
  logic [15:0]               Trash_Count;
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } sb_entry_t;

  sb_entry_t q0[$];
  sb_entry_t q1[$];
  int        pass_cnt  = 0;
  int        total_cnt = 0;
  int        cycle     = 0;
  logic      lat_chk   = 1'b0;

  split_radio_array #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Receive(Receive),
    .Receive_Valid(Receive_Valid),
    .Receive_Ready(Receive_Ready),
    .Route(Route),
    .Broadcast(Broadcast),
`ifdef SPLIT_RADIO_TRASH_COUNT_EN
    .Trash_Count(Trash_Count),
`endif
    .Out_Data(Out_Data),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle <= cycle + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [WIDTH-1:0] data,
                                input logic [ROUTE_W-1:0] route, input logic bcast);
    Receive_Valid = valid;
    Receive       = data;
    Route         = route;
    Broadcast     = bcast;
    #1;
  endtask

  // Scoreboard: handshakes are sampled on the falling edge, where every input
  // and combinational output has settled for the coming rising edge.
  always @(negedge Clock) begin
    sb_entry_t e;
    if (!Reset_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (Out_Valid[0] && Out_Ready[0]) begin
        if (q0.size() == 0) check_output("ch0_spurious", {31'd0, Out_Valid[0]}, 32'd0);
        else begin
          e = q0.pop_front();
          check_output("ch0_data", {24'd0, Out_Data[7:0]}, {24'd0, e.data});
          if (lat_chk) check_output("ch0_latency", cycle - e.cyc, DEPTH);
        end
      end
      if (Out_Valid[1] && Out_Ready[1]) begin
        if (q1.size() == 0) check_output("ch1_spurious", {31'd0, Out_Valid[1]}, 32'd0);
        else begin
          e = q1.pop_front();
          check_output("ch1_data", {24'd0, Out_Data[15:8]}, {24'd0, e.data});
          if (lat_chk) check_output("ch1_latency", cycle - e.cyc, DEPTH);
        end
      end
      if (Receive_Valid && Receive_Ready) begin
        e.data = Receive;
        e.cyc  = cycle;
        if (Broadcast) begin
          q0.push_back(e);
          q1.push_back(e);
        end else if (Route == 0) q0.push_back(e);
        else if (Route == 1)     q1.push_back(e);
      end
    end
  end

  initial begin
    Reset_n   = 1'b0;
    Out_Ready = 2'b11;
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    #1;
    check_output("reset_out_valid", {30'd0, Out_Valid}, 32'd0);
    check_output("reset_out_data", {16'd0, Out_Data}, 32'd0);
    check_output("reset_ready", {31'd0, Receive_Ready}, 32'd1);
    #20 Reset_n = 1'b1;
    tick();

    // Reset with three words in flight, the oldest parked on the output
    $display("[TB] reset mid-stream");
    Out_Ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 8'h31 + 8'(i), 2'd0, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    tick();
    check_output("pre_reset_valid", {31'd0, Out_Valid[0]}, 32'd1);
    check_output("pre_reset_data", {24'd0, Out_Data[7:0]}, 32'h31);
    #2 Reset_n = 1'b0;
    #1;
    check_output("async_reset_valid", {30'd0, Out_Valid}, 32'd0);
    check_output("async_reset_data", {16'd0, Out_Data}, 32'd0);
    @(posedge Clock);
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    Out_Ready = 2'b11;
    repeat (8) tick();
    check_output("no_stale_word", {30'd0, Out_Valid}, 32'd0);

    // Latency and throughput on channel 1
    $display("[TB] latency and throughput");
    lat_chk = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, 8'(i), 2'd1, 1'b0);
      check_output("stream_ready", {31'd0, Receive_Ready}, 32'd1);
      check_output("ch0_idle", {31'd0, Out_Valid[0]}, 32'd0);
      tick();
    end
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (8) tick();
    lat_chk = 1'b0;

    // Backpressure on channel 0, channel 1 stays open
    $display("[TB] backpressure");
    Out_Ready = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b1, 8'(i), 2'd0, 1'b0);
      check_output("bp_ready", {31'd0, Receive_Ready}, (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    apply_stimulus(1'b1, 8'h77, 2'd1, 1'b0);
    check_output("bp_other_route_ready", {31'd0, Receive_Ready}, 32'd1);
    tick();
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (6) tick();
    Out_Ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output("drain_valid", {31'd0, Out_Valid[0]}, 32'd1);
      check_output("drain_data", {24'd0, Out_Data[7:0]}, 32'(k + 1));
      tick();
    end
    check_output("drain_done", {31'd0, Out_Valid[0]}, 32'd0);

    // Broadcast with channel 1 stalled
    $display("[TB] broadcast");
    Out_Ready = 2'b01;
    apply_stimulus(1'b1, 8'hA5, 2'd0, 1'b1);
    check_output("bc_ready", {31'd0, Receive_Ready}, 32'd1);
    tick();
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (3) tick();
    check_output("bc_valid_n4", {30'd0, Out_Valid}, 32'd3);
    check_output("bc_data_n4", {16'd0, Out_Data}, 32'hA5A5);
    tick();
    check_output("bc_ch1_hold_valid", {30'd0, Out_Valid}, 32'd2);
    check_output("bc_ch1_hold_data", {24'd0, Out_Data[15:8]}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 8'h11 + 8'(i), 2'd1, 1'b0);
      check_output("fill_ch1_ready", {31'd0, Receive_Ready}, 32'd1);
      tick();
    end
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (3) tick();
    check_output("ch0_route_ready", {31'd0, Receive_Ready}, 32'd1);
    apply_stimulus(1'b1, 8'h5A, 2'd0, 1'b1);
    check_output("bc_blocked", {31'd0, Receive_Ready}, 32'd0);
    tick();
    check_output("bc_still_blocked", {31'd0, Receive_Ready}, 32'd0);
    check_output("bc_ch1_still_a5", {24'd0, Out_Data[15:8]}, 32'hA5);
    Out_Ready = 2'b11;
    #1;
    check_output("bc_unblocked", {31'd0, Receive_Ready}, 32'd1);
    tick();
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (10) tick();

    // Trash routes never reach a channel
    $display("[TB] trash");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'hE0 + 8'(i), (i % 2 == 0) ? 2'd3 : 2'd2, 1'b0);
      check_output("trash_ready", {31'd0, Receive_Ready}, 32'd1);
      tick();
    end
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (6) begin
      check_output("trash_no_output", {30'd0, Out_Valid}, 32'd0);
      tick();
    end
`ifdef SPLIT_RADIO_TRASH_COUNT_EN
    check_output("trash_count", {16'd0, Trash_Count}, 32'd5);
    $display("[TB] trash counter saturation");
    apply_stimulus(1'b1, 8'h00, 2'd3, 1'b0);
    repeat (65529) tick();
    check_output("trash_count_near_max", {16'd0, Trash_Count}, 32'hFFFE);
    repeat (6) tick();
    check_output("trash_count_saturated", {16'd0, Trash_Count}, 32'hFFFF);
    apply_stimulus(1'b0, 8'h00, 2'd0, 1'b0);
    tick();
`endif

    check_output("ch0_leftover", q0.size(), 32'd0);
    check_output("ch1_leftover", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
